// File: rtl/ps2_line_serializer_module.sv
// Streams a packed line buffer out one character per valid/ready handshake,
// stopping at NUL/terminator or after LINE_CHARS characters, then emits TERM_CHAR.
module ps2_line_serializer_module #(
  parameter int                LINE_CHARS = 32,
  parameter int                CHAR_W     = 8,
  parameter logic [CHAR_W-1:0] TERM_CHAR  = 8'h0a
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic [LINE_CHARS*CHAR_W-1:0]       line_content,
  input  logic                               line_load,
  output logic                               load_ready,
  output logic [CHAR_W-1:0]                  char_out,
  output logic                               char_valid,
  input  logic                               char_ready,
  output logic                               line_done,
  output logic [$clog2(LINE_CHARS+1)-1:0]    char_count
);

  localparam int LINE_W = LINE_CHARS * CHAR_W;
  localparam int IDX_W  = $clog2(LINE_CHARS);
  localparam int CNT_W  = $clog2(LINE_CHARS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_CHARS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    TERM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CHAR_W-1:0]   top;
  logic                end_of_content;

  assign top            = shreg_q[LINE_W-1 -: CHAR_W];
  assign end_of_content = (top == '0) || (top == TERM_CHAR);
  assign char_count     = count_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Outputs decode only registered state so they never follow char_ready or line_load.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    count_d    = count_q;
    char_out   = '0;
    char_valid = 1'b0;
    load_ready = 1'b0;
    line_done  = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (line_load) begin
          shreg_d = line_content;
          idx_d   = '0;
          count_d = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        // A NUL or terminator byte costs one idle cycle while we switch to TERM.
        if (end_of_content) begin
          state_d = TERM;
        end else begin
          char_out   = top;
          char_valid = 1'b1;
          if (char_ready) begin
            shreg_d = shreg_q << CHAR_W;
            count_d = count_q + CNT_W'(1);
            if (idx_q == LAST_IDX) begin
              state_d = TERM;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end

      TERM: begin
        char_out   = TERM_CHAR;
        char_valid = 1'b1;
        if (char_ready) begin
          state_d = DONE;
        end
      end

      DONE: begin
        line_done = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_line_serializer_module.sv
// Randomized and directed bench for ps2_line_serializer_module, checked every
// cycle against a queue-of-expected-characters model of the line.
module tb_ps2_line_serializer_module;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [255:0] line_content = '0;
  logic         line_load = 1'b0;
  logic         char_ready = 1'b0;
  logic         load_ready;
  logic [7:0]   char_out;
  logic         char_valid;
  logic         line_done;
  logic [5:0]   char_count;

  ps2_line_serializer_module dut (
    .clock        (clock),
    .resetn       (resetn),
    .line_content (line_content),
    .line_load    (line_load),
    .load_ready   (load_ready),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .line_done    (line_done),
    .char_count   (char_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model state: characters still owed for the current line, and bookkeeping.
  logic [7:0] expq[$];
  logic [7:0] acc_log[$];
  bit         busy = 0;
  int         cnt = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_char = '0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         done_base = 0;
  int         load_cyc = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected character stream for a line: content up to NUL/LF or 32 chars, then LF.
  function automatic void push_line(input logic [255:0] c);
    for (int k = 0; k < 32; k++) begin
      logic [7:0] b;
      b = c[255-8*k -: 8];
      if (b == 8'h00 || b == 8'h0a) break;
      expq.push_back(b);
    end
    expq.push_back(8'h0a);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] c;
    int len;
    logic [7:0] b;
    c = '0;
    len = $urandom_range(0, 32);
    for (int k = 0; k < 32; k++) begin
      if (k < len) begin
        do b = 8'($urandom_range(1, 255)); while (b == 8'h0a);
      end else if (k == len) begin
        b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h0a;
      end else begin
        b = 8'($urandom);
      end
      c[255-8*k -: 8] = b;
    end
    return c;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Compare process: outputs are settled at the falling edge; the handshakes
  // seen here are the ones the next rising edge will take.
  initial forever begin
    @(negedge clock);
    if (!resetn) begin
      chk_eq("rst_valid", char_valid, 0);
      chk_eq("rst_char", char_out, 0);
      chk_eq("rst_load_ready", load_ready, 1);
      chk_eq("rst_done", line_done, 0);
      chk_eq("rst_count", char_count, 0);
      expq.delete();
      busy = 0;
      cnt = 0;
      prev_stall = 0;
    end else begin
      chk_eq("load_ready", load_ready, !busy);
      chk_eq("char_count", char_count, cnt);
      if (prev_stall) begin
        chk_eq("stall_valid", char_valid, 1);
        chk_eq("stall_char", char_out, prev_char);
      end
      if (char_valid) begin
        chk_eq("valid_expected", expq.size() > 0, 1);
        if (expq.size() > 0) chk_eq("char_out", char_out, expq[0]);
      end else begin
        chk_eq("idle_char_zero", char_out, 0);
      end
      if (line_done) begin
        chk_eq("done_expected", busy && expq.size() == 0, 1);
        done_cnt++;
        done_cyc = cyc;
        busy = 0;
      end
      prev_stall = char_valid && !char_ready;
      prev_char = char_out;
      if (char_valid && char_ready && expq.size() > 0) begin
        if (expq.size() > 1) cnt++;
        acc_log.push_back(expq.pop_front());
      end
      if (line_load && load_ready) begin
        push_line(line_content);
        cnt = 0;
        busy = 1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the first cycle after the load edge.
  task automatic do_load(input logic [255:0] c);
    int t = 0;
    while (!load_ready && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    chk_eq("load_ready_wait", load_ready, 1);
    acc_log.delete();
    done_base = done_cnt;
    line_content = c;
    line_load = 1'b1;
    @(posedge clock); #1;
    load_cyc = cyc;
    line_load = 1'b0;
  endtask

  // d counts the cycle right after the load edge as cycle 1.
  task automatic wait_done(output int d);
    int t = 0;
    while (done_cnt == done_base && t < 400) begin
      @(posedge clock); #1;
      t++;
    end
    chk_eq("done_timeout", done_cnt > done_base, 1);
    d = done_cyc - load_cyc + 1;
  endtask

  initial begin
    logic [255:0] c;
    logic [255:0] alt;
    int d;
    int t;
    int base;
    int ph;

    #1 resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_eq("reset_valid", char_valid, 0);
    chk_eq("reset_load_ready", load_ready, 1);
    chk_eq("reset_count", char_count, 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // "HI"
    char_ready = 1'b1;
    c = '0;
    c[255:240] = 16'h4849;
    do_load(c);
    chk_eq("hi_first_valid", char_valid, 1);
    chk_eq("hi_first_char", char_out, 8'h48);
    wait_done(d);
    chk_eq("hi_done_cycle", d, 5);
    chk_eq("hi_len", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk_eq("hi_c0", acc_log[0], 8'h48);
      chk_eq("hi_c1", acc_log[1], 8'h49);
      chk_eq("hi_c2", acc_log[2], 8'h0a);
    end
    chk_eq("hi_count", char_count, 2);

    // Full 32-character line 0x41..0x60
    for (int k = 0; k < 32; k++) c[255-8*k -: 8] = 8'(8'h41 + k);
    do_load(c);
    wait_done(d);
    chk_eq("full_done_cycle", d, 34);
    chk_eq("full_len", acc_log.size(), 33);
    if (acc_log.size() == 33) begin
      chk_eq("full_c0", acc_log[0], 8'h41);
      chk_eq("full_c31", acc_log[31], 8'h60);
      chk_eq("full_term", acc_log[32], 8'h0a);
    end
    chk_eq("full_count", char_count, 32);

    // Empty line
    do_load('0);
    t = 0;
    while (!load_ready && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    chk_eq("empty_ready_cycle", cyc - load_cyc + 1, 4);
    chk_eq("empty_done_once", done_cnt - done_base, 1);
    chk_eq("empty_len", acc_log.size(), 1);
    if (acc_log.size() == 1) chk_eq("empty_term", acc_log[0], 8'h0a);
    chk_eq("empty_count", char_count, 0);

    // "ABC" with char_ready pattern 1,0,0,1,...
    c = '0;
    c[255:232] = 24'h414243;
    do_load(c);
    ph = 0;
    t = 0;
    while (done_cnt == done_base && t < 100) begin
      char_ready = (ph % 3 == 0);
      ph++;
      @(posedge clock); #1;
      t++;
    end
    chk_eq("abc_done", done_cnt > done_base, 1);
    chk_eq("abc_len", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      chk_eq("abc_c0", acc_log[0], 8'h41);
      chk_eq("abc_c1", acc_log[1], 8'h42);
      chk_eq("abc_c2", acc_log[2], 8'h43);
      chk_eq("abc_c3", acc_log[3], 8'h0a);
    end
    char_ready = 1'b1;

    // Loads during SEND and in the DONE cycle are ignored
    c = '0;
    c[255:216] = 40'h48454c4c4f;
    alt = '0;
    alt[255:232] = 24'h58595a;
    do_load(c);
    @(posedge clock); #1;
    line_content = alt;
    line_load = 1'b1;
    @(posedge clock); #1;
    line_load = 1'b0;
    t = 0;
    while (!line_done && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    chk_eq("ign_done_seen", line_done, 1);
    line_load = 1'b1;
    @(posedge clock); #1;
    line_load = 1'b0;
    chk_eq("ign_idle_after_done", load_ready, 1);
    chk_eq("ign_no_restart", char_valid, 0);
    chk_eq("ign_len", acc_log.size(), 6);
    if (acc_log.size() == 6) begin
      chk_eq("ign_c0", acc_log[0], 8'h48);
      chk_eq("ign_c4", acc_log[4], 8'h4f);
      chk_eq("ign_c5", acc_log[5], 8'h0a);
    end
    chk_eq("ign_count", char_count, 5);

    // Reset while the 5th of 10 characters is being offered
    c = '0;
    c[255:176] = 80'h4142434445464748494a;
    do_load(c);
    t = 0;
    while (!(char_valid && char_out == 8'h45) && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    chk_eq("mid_reached_5th", char_out, 8'h45);
    base = done_cnt;
    resetn = 1'b0;
    #1;
    chk_eq("mid_rst_valid", char_valid, 0);
    chk_eq("mid_rst_load_ready", load_ready, 1);
    chk_eq("mid_rst_done", line_done, 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk_eq("mid_no_done", done_cnt, base);
    do_load(c);
    chk_eq("mid_restart_char", char_out, 8'h41);
    wait_done(d);
    chk_eq("mid_restart_cycle", d, 13);
    chk_eq("mid_restart_count", char_count, 10);

    // Random traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      char_ready = ($urandom_range(0, 3) != 0);
      line_load = ($urandom_range(0, 7) == 0);
      line_content = rand_line();
      resetn = ($urandom_range(0, 999) != 0);
      @(posedge clock); #1;
    end
    resetn = 1'b1;
    line_load = 1'b0;
    char_ready = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    chk_eq("drain_empty", expq.size(), 0);
    chk_eq("drain_idle", load_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL global_timeout: got 0x0, expected 0x1");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_line_serializer_module.md
# ps2_line_serializer_module

Transmit-side counterpart of the PS/2 line assembler: accepts a packed 256-bit line buffer of up to 32 ASCII characters, first character in bits [255:248], and emits it one character per valid/ready handshake. Content ends at the first 0x00 or terminator byte, or after 32 characters. A single terminator character (0x0a) follows the content. It feeds character-at-a-time consumers such as the text console or echo path, and can loop a finished line back into any line-oriented sink.

## Interface
- LINE_CHARS, 32, maximum content characters per line.
- CHAR_W, 8, bits per character.
- TERM_CHAR, 8'h0a, terminator emitted after content. A TERM_CHAR byte found in the content also ends the content.
- clock  in  1  rising-edge system clock; the block's only clock.
- resetn  in  1  asynchronous, active-low reset.
- line_content  in  256  packed line: char k at [255-8k -: 8]; sampled only on an accepted load.
- line_load  in  1  request to send line_content; accepted only when load_ready=1.
- load_ready  out  1  high only in IDLE.
- char_out  out  8  current character.
- char_valid  out  1  char_out is valid.
- char_ready  in  1  consumer accepts char_out when char_valid & char_ready at a rising edge.
- line_done  out  1  one-cycle pulse after the terminator is accepted.
- char_count  out  6  content characters accepted for the current or last line (0..32).

## Operation
- State machine states: IDLE, SEND, TERM, DONE.
- Registers:
  - 256-bit shift register `shreg`.
  - 5-bit index `idx`.
  - 6-bit `char_count`.
  - State register.
- IDLE:
  - load_ready=1 and char_valid=0.
  - On line_load: shreg <= line_content, idx <= 0, char_count <= 0, then go to SEND.
- SEND: the current character is `top = shreg[255:248]`.
  - If top is 0x00 or TERM_CHAR: char_valid=0, and the next state is TERM. This cycle is lost; no handshake occurs.
  - Otherwise char_out=top and char_valid=1. On accept:
    - shreg <= shreg << 8, char_count <= char_count+1.
    - If idx==31, go to TERM; else idx <= idx+1.
  - Without accept, all registers hold.
- TERM:
  - char_out=TERM_CHAR and char_valid=1.
  - On accept, go to DONE.
- DONE:
  - line_done=1 for exactly one cycle, char_valid=0, load_ready=0.
  - Next state is IDLE.
- char_out and char_valid are decoded only from registered state (state, shreg). They are stable while char_valid=1 and char_ready=0, and never depend combinationally on char_ready or line_load.
- When char_valid=0, char_out=0x00.
- char_count holds its final value in DONE and IDLE until the next accepted load.
- line_load outside IDLE is ignored, with no buffering; this includes a load in the DONE cycle.
- A NUL or TERM_CHAR byte ends the content; characters after it are never emitted.

## Timing
- Reset (resetn=0, asynchronous, effective immediately):
  - state=IDLE, shreg=0, idx=0, char_count=0.
  - char_valid=0, char_out=0x00, line_done=0, load_ready=1 once the state is IDLE.
- Reset mid-line discards the line; no terminator or line_done is produced.
- Load latency: line_load accepted at edge N gives char_valid=1 (first character) in the cycle after edge N.
- With char_ready held at 1, a line of n content characters (n ≤ 32) costs the following cycles after load:
  - n+1 transfers on consecutive cycles.
  - Plus 1 lost cycle if n<32 (end-of-content detect).
  - Plus 1 DONE cycle.
- Minimum spacing between accepted loads:
  - Full 32-character line: 35 cycles.
  - Empty line: 4 cycles (SEND, TERM, DONE, IDLE).
- Backpressure: any number of char_ready=0 cycles is allowed in SEND or TERM. Characters are neither lost nor duplicated.
- char_ready is ignored outside SEND/TERM, and when char_valid=0.

## Test plan
- Reset then load "HI" (0x48,0x49 in [255:240], rest 0), char_ready=1 → char_out sequence 0x48, 0x49, 0x0a on consecutive valid cycles, then line_done pulse one cycle later, char_count=2.
- Full line with bytes 0x41..0x60 (32 chars), char_ready=1 → 32 characters in order, then 0x0a; line_done exactly 34 cycles after the load edge; char_count=32.
- All-zero line → no content characters, a single 0x0a emitted; char_count=0; load_ready returns 4 cycles after load.
- "ABC" with char_ready toggling 1,0,0,1,… → char_out/char_valid stable during stalls; exactly A,B,C,0x0a accepted.
- line_load pulsed in SEND and in DONE with a different line_content → ignored; original line completes unchanged.
- resetn asserted while sending the 5th of 10 characters → char_valid=0 and load_ready=1 immediately, no line_done; a fresh load afterwards starts from character 0.
